// File: rtl/register_file.sv
// Bank of DEPTH x WIDTH registers: one write port, two read ports, in-place inc/dec with wrap flag.
// Latency: writes and inc/dec land on the next rising edge; reads are combinational; wrap is registered.
// Backpressure: none, every request is accepted on the edge it is presented.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   we, waddr, wdata      write port
//   inc, dec, iaddr       increment/decrement port (inc and dec together is a no-op)
//   raddr_a/b, rdata_a/b  combinational read ports, optional same-cycle write bypass
//   wrap                  high for one cycle after an inc/dec that wrapped around
module register_file #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 8,
    parameter int                 ADDR_W    = $clog2(DEPTH),
    parameter bit                 ZERO_R0   = 1'b0,
    parameter bit                 BYPASS    = 1'b1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              inc,
    input  logic              dec,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              wrap
);

    logic [WIDTH-1:0] regs [DEPTH];

    logic             wr_go;
    logic             id_go;
    logic [WIDTH-1:0] id_cur;
    logic [WIDTH-1:0] id_nxt;
    logic             wrap_nxt;

    // An address is usable when it maps onto a physical register and is not
    // the hard-wired zero register.
    function automatic logic legal(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && !(ZERO_R0 && (a == '0));
    endfunction

    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] r;
        r = '0;
        if (legal(a)) begin
            if (BYPASS && we && (waddr == a)) begin
                r = wdata;
            end else begin
                r = regs[a];
            end
        end
        return r;
    endfunction

    always_comb begin
        rdata_a = read_port(raddr_a);
        rdata_b = read_port(raddr_b);
    end

    // A write to the same address as the inc/dec wins; the inc/dec is dropped
    // and cannot raise wrap.
    always_comb begin
        wr_go    = we && legal(waddr);
        id_go    = (inc ^ dec) && legal(iaddr) && !(we && (waddr == iaddr));
        id_cur   = '0;
        id_nxt   = '0;
        wrap_nxt = 1'b0;
        if (id_go) begin
            id_cur   = regs[iaddr];
            id_nxt   = inc ? (id_cur + 1'b1) : (id_cur - 1'b1);
            wrap_nxt = inc ? (&id_cur) : (id_cur == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (ZERO_R0 && (i == 0)) ? '0 : RESET_VAL;
            end
            wrap <= 1'b0;
        end else begin
            if (wr_go) begin
                regs[waddr] <= wdata;
            end
            if (id_go) begin
                regs[iaddr] <= id_nxt;
            end
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-register storage block for the 8-bit CPU datapath, generalising the single 8-bit register into a bank of DEPTH registers of WIDTH bits. It provides one write port, two independent read ports and an in-place increment/decrement port with wrap detection, so the program counter, stack pointer and general-purpose registers can share one block. It sits between the ALU result bus (write port) and the ALU operand muxes (read ports A/B); the control unit drives the increment/decrement port.

## Interface
- WIDTH, 8: bits per register.
- DEPTH, 8: number of registers; legal range 2..256.
- ADDR_W, $clog2(DEPTH): address width.
- ZERO_R0, 0: when 1, register 0 always reads 0 and ignores all writes and inc/dec.
- BYPASS, 1: when 1, read ports forward same-cycle write data.
- RESET_VAL, 0: value loaded into every register on reset.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; asserting it (0) clears the bank immediately.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- inc  in  1  increment register iaddr by 1.
- dec  in  1  decrement register iaddr by 1.
- iaddr  in  ADDR_W  inc/dec target address.
- raddr_a  in  ADDR_W  read port A address.
- rdata_a  out  WIDTH  read port A data.
- raddr_b  in  ADDR_W  read port B address.
- rdata_b  out  WIDTH  read port B data.
- wrap  out  1  one-cycle flag: the previous edge's inc/dec wrapped.

## Operation
- Reset (reset=0, asynchronous): all registers := RESET_VAL (R0 := 0 when ZERO_R0=1); wrap := 0. Held while reset=0; normal operation resumes on the first rising edge after reset=1.
- Write: on the rising edge with we=1, reg[waddr] := wdata.
- Inc/dec: on the rising edge, inc=1 & dec=0 gives reg[iaddr] := reg[iaddr]+1 mod 2^WIDTH; dec=1 & inc=0 gives reg[iaddr]-1 mod 2^WIDTH. inc=1 & dec=1 is a no-op with wrap=0.
- wrap register: set to 1 on an edge where inc is applied to all-ones (result 0) or dec is applied to 0 (result all-ones); otherwise cleared to 0 on every edge.
- Simultaneous write and inc/dec, same address: the write wins, the inc/dec is discarded, wrap=0.
- Simultaneous write and inc/dec, different addresses: both take effect on the same edge.
- Out-of-range addresses (≥ DEPTH, non-power-of-2 DEPTH only): writes and inc/dec are ignored; reads return 0.
- ZERO_R0=1: writes and inc/dec targeting R0 are ignored (wrap=0); reads of R0 return 0, including under bypass.
- Reads are combinational: rdata_x = reg[raddr_x]. With BYPASS=1, if we=1 and waddr==raddr_x (legal, non-zeroed address), rdata_x = wdata instead. Inc/dec results are never bypassed.
- Both read ports may address the same register, or the write address, simultaneously.

## Timing
- Write/inc/dec latency: 1 clock; the new value is visible on rdata from the edge onward (or combinationally before the edge with BYPASS=1 for writes).
- Read latency: 0 cycles (combinational from storage and the write port).
- wrap: registered; high for exactly the one cycle following the wrapping edge.
- No handshake: every request is accepted on the edge on which it is presented.
- Reset mid-operation: pending write or inc/dec requests on the edge coincident with reset=0 are lost; the bank reads RESET_VAL.

## Test plan
- Reset/write/read: assert reset=0, check all 8 registers read 0x00; write R3=0xAA, R5=0x55; read A=R3, B=R5 -> 0xAA and 0x55 one cycle later.
- Bypass: with we=1, waddr=2, wdata=0xF0, raddr_a=2 before the edge -> rdata_a=0xF0 combinationally; with BYPASS=0 -> the old R2 value until the edge.
- Inc/dec wrap: R1=0xFF, inc on R1 -> R1=0x00 and wrap=1 for one cycle; dec on R1 -> 0xFF and wrap=1; inc on 0x10 -> 0x11 and wrap=0.
- Collisions: we on R4=0x20 plus inc on R4 -> R4=0x20, wrap=0; we on R4=0x20 plus inc on R6 (0x07) -> R4=0x20, R6=0x08; inc=dec=1 -> unchanged.
- ZERO_R0=1: write R0=0x77 and inc on R0 -> R0 reads 0x00 on both ports, also during bypass.
- Async reset mid-stream: drop reset between edges while R3=0xAA -> R3=0x00 immediately (no edge needed) and wrap=0; a write presented on the reset edge is not stored.
